// File: rtl/if_pad_fill_scheduler.sv
// if_pad_fill_scheduler: streams one IFMap row from the read buffer into the
// PE's circular scratchpad. It tracks occupancy so that no slot is ever
// overwritten, flags when a full filter window is resident, and retires
// STRIDE slots for each window the PE consumes.
// Optional build macro IF_ZERO_PAD_EN: writes PAD_ZEROS zero words before and
// after the row. These writes do not pop the read buffer. The feature adds
// the pad_zero output.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; no reads or writes are issued
// FILL  | issuing buffer reads (and zero writes) while slots are free
// DRAIN | all words written; the PE consumes until < FILT_SIZE remain
module if_pad_fill_scheduler #(
  parameter int PAD_DEPTH = 16,
  parameter int FILT_SIZE = 4,
  parameter int STRIDE    = 1,
  parameter int ROW_LEN   = 32,
`ifdef IF_ZERO_PAD_EN
  parameter int PAD_ZEROS = 1,
`endif
  parameter int ADDR_W    = $clog2(PAD_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              buffer_valid,
  input  logic              window_consumed,
  output logic              buffer_read_enable,
  output logic              pad_wen,
  output logic [ADDR_W-1:0] pad_waddr,
  output logic [ADDR_W-1:0] pad_raddr_base,
  output logic              window_ready,
  output logic              busy,
`ifdef IF_ZERO_PAD_EN
  output logic              pad_zero,
`endif
  output logic              row_done
);

  // Occupancy has to represent a completely full pad, so it is one bit wider
  // than an address.
  localparam int OCC_W = ADDR_W + 1;
  localparam int FCH_W = $clog2(ROW_LEN + 1);

  localparam logic [OCC_W-1:0]  STRIDE_O = OCC_W'(STRIDE);
  localparam logic [OCC_W-1:0]  FILT_O   = OCC_W'(FILT_SIZE);
  localparam logic [OCC_W-1:0]  DEPTH_O  = OCC_W'(PAD_DEPTH);
  localparam logic [OCC_W-1:0]  ONE_O    = OCC_W'(1);
  // Truncating to ADDR_W bits gives the modulo-PAD_DEPTH wrap for free.
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [FCH_W-1:0]  ROW_F    = FCH_W'(ROW_LEN);
  localparam logic [FCH_W-1:0]  ONE_F    = FCH_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [ADDR_W-1:0]  rptr_q, rptr_d;
  logic [FCH_W-1:0]   fetched_q, fetched_d;
  logic               inflight_q, inflight_d;
  logic               pad_wen_q, pad_wen_d;

  logic               slot_free;
  logic               rows_left;
  logic               rd_issue;
  logic               issue_any;
  logic               all_issued;
  logic               honour;

`ifdef IF_ZERO_PAD_EN
  localparam int ZCNT_W = $clog2(PAD_ZEROS + 2);
  localparam logic [ZCNT_W-1:0] Z_C   = ZCNT_W'(PAD_ZEROS);
  localparam logic [ZCNT_W-1:0] ONE_Z = ZCNT_W'(1);

  logic [ZCNT_W-1:0]  zpre_q, zpre_d;
  logic [ZCNT_W-1:0]  zpost_q, zpost_d;
  logic               pad_zero_q, pad_zero_d;
  logic               zero_pre;
  logic               zero_post;
  logic               zero_issue;
`endif

  // Issue decode: a slot is free only if neither resident nor pending words fill it.
  always_comb begin
    slot_free  = ({1'b0, occ_q} + (OCC_W + 1)'(inflight_q)) < {1'b0, DEPTH_O};
    rows_left  = fetched_q < ROW_F;
`ifdef IF_ZERO_PAD_EN
    zero_pre   = zpre_q < Z_C;
    zero_post  = !rows_left && (zpost_q < Z_C);
    rd_issue   = (state_q == ST_FILL) && slot_free && !zero_pre && rows_left && buffer_valid;
    zero_issue = (state_q == ST_FILL) && slot_free && (zero_pre || zero_post);
    issue_any  = rd_issue || zero_issue;
    all_issued = !rows_left && !zero_pre && !zero_post;
`else
    rd_issue   = (state_q == ST_FILL) && slot_free && rows_left && buffer_valid;
    issue_any  = rd_issue;
    all_issued = !rows_left;
`endif
  end

  assign window_ready       = (occ_q >= FILT_O) && (state_q != ST_IDLE);
  assign row_done           = (state_q == ST_DRAIN) && (occ_q < FILT_O);
  assign honour             = window_ready && window_consumed;
  assign busy               = (state_q != ST_IDLE);
  assign buffer_read_enable = rd_issue;
  assign pad_wen            = pad_wen_q;
  assign pad_waddr          = wptr_q;
  assign pad_raddr_base     = rptr_q;
`ifdef IF_ZERO_PAD_EN
  assign pad_zero           = pad_zero_q;
`endif

  // Next state plus pointer and counter updates; row_done restarts the pad from address 0.
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fetched_d  = fetched_q;
    inflight_d = inflight_q;
    pad_wen_d  = issue_any;
`ifdef IF_ZERO_PAD_EN
    zpre_d     = zpre_q;
    zpost_d    = zpost_q;
    pad_zero_d = zero_issue;
`endif

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (all_issued && !inflight_q) state_d = ST_DRAIN;
      ST_DRAIN: if (row_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (pad_wen_q) begin
      occ_d  = occ_d + ONE_O;
      wptr_d = wptr_q + ONE_A;
    end
    if (honour) begin
      occ_d  = occ_d - STRIDE_O;
      rptr_d = rptr_q + STRIDE_A;
    end
    if (rd_issue) fetched_d = fetched_q + ONE_F;

    // A new issue in the same cycle as a landing write keeps the flag set.
    if (issue_any)      inflight_d = 1'b1;
    else if (pad_wen_q) inflight_d = 1'b0;

`ifdef IF_ZERO_PAD_EN
    if (zero_issue && zero_pre)  zpre_d  = zpre_q + ONE_Z;
    if (zero_issue && zero_post) zpost_d = zpost_q + ONE_Z;
`endif

    if (row_done) begin
      occ_d     = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      fetched_d = '0;
`ifdef IF_ZERO_PAD_EN
      zpre_d    = '0;
      zpost_d   = '0;
`endif
    end
  end

  // State register with synchronous active-low reset; pending data is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fetched_q  <= '0;
      inflight_q <= 1'b0;
      pad_wen_q  <= 1'b0;
`ifdef IF_ZERO_PAD_EN
      zpre_q     <= '0;
      zpost_q    <= '0;
      pad_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fetched_q  <= fetched_d;
      inflight_q <= inflight_d;
      pad_wen_q  <= pad_wen_d;
`ifdef IF_ZERO_PAD_EN
      zpre_q     <= zpre_d;
      zpost_q    <= zpost_d;
      pad_zero_q <= pad_zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_pad_fill_scheduler.sv
// Bench for if_pad_fill_scheduler: one instance with STRIDE=1 and one with
// STRIDE=2 share the stimulus. The reference model keeps per-row counts of
// issued, written and consumed words. Every output is derived from those counts.
module tb_if_pad_fill_scheduler;
  localparam int DEPTH = 16;
  localparam int FILT  = 4;
  localparam int ROWL  = 32;
  localparam int AW    = 4;
  localparam int STR0  = 1;
  localparam int STR1  = 2;
`ifdef IF_ZERO_PAD_EN
  localparam int ZP = 1;
`else
  localparam int ZP = 0;
`endif
  localparam int TOTAL = ROWL + 2 * ZP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, bvalid;
  logic          wcons [2];
  logic          bre [2], wen [2], wr [2], busy [2], rdone [2];
  logic [AW-1:0] waddr [2], raddr [2];
`ifdef IF_ZERO_PAD_EN
  logic          pzero [2];
`endif

  if_pad_fill_scheduler #(.PAD_DEPTH(DEPTH), .FILT_SIZE(FILT), .STRIDE(STR0), .ROW_LEN(ROWL)
`ifdef IF_ZERO_PAD_EN
    , .PAD_ZEROS(ZP)
`endif
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .buffer_valid(bvalid),
    .window_consumed(wcons[0]), .buffer_read_enable(bre[0]), .pad_wen(wen[0]),
    .pad_waddr(waddr[0]), .pad_raddr_base(raddr[0]), .window_ready(wr[0]),
    .busy(busy[0]),
`ifdef IF_ZERO_PAD_EN
    .pad_zero(pzero[0]),
`endif
    .row_done(rdone[0])
  );

  if_pad_fill_scheduler #(.PAD_DEPTH(DEPTH), .FILT_SIZE(FILT), .STRIDE(STR1), .ROW_LEN(ROWL)
`ifdef IF_ZERO_PAD_EN
    , .PAD_ZEROS(ZP)
`endif
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .buffer_valid(bvalid),
    .window_consumed(wcons[1]), .buffer_read_enable(bre[1]), .pad_wen(wen[1]),
    .pad_waddr(waddr[1]), .pad_raddr_base(raddr[1]), .window_ready(wr[1]),
    .busy(busy[1]),
`ifdef IF_ZERO_PAD_EN
    .pad_zero(pzero[1]),
`endif
    .row_done(rdone[1])
  );

  int cnt_pass  = 0;
  int cnt_total = 0;

  // Model: phase 0 idle, 1 fetching, 2 draining; per-row word counts.
  int m_phase [2];
  int m_iss   [2];
  int m_wr    [2];
  int m_con   [2];

  int n_bre [2], n_wen [2], n_hon [2], n_done [2], n_zero [2], n_bad [2];

  function automatic int stride_of(input int i);
    return (i == 0) ? STR0 : STR1;
  endfunction

  function automatic bit is_zero_slot(input int idx);
    return (idx < ZP) || (idx >= ZP + ROWL);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    cnt_total++;
    if (obs == exp) cnt_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear(input int i);
    m_phase[i] = 0;
    m_iss[i]   = 0;
    m_wr[i]    = 0;
    m_con[i]   = 0;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      n_bre[i] = 0; n_wen[i] = 0; n_hon[i] = 0;
      n_done[i] = 0; n_zero[i] = 0; n_bad[i] = 0;
    end
  endtask

  // Called between edges: compare all outputs, then move the model past the next edge.
  task automatic check_and_advance();
    for (int i = 0; i < 2; i++) begin
      int occ, pend;
      bit zslot, can, e_bre, e_rdy, e_done, hon;
      occ    = m_wr[i] - stride_of(i) * m_con[i];
      pend   = m_iss[i] - m_wr[i];
      zslot  = is_zero_slot(m_iss[i]);
      can    = (m_phase[i] == 1) && (m_iss[i] < TOTAL) && (occ + pend < DEPTH) && (zslot || bvalid);
      e_bre  = can && !zslot;
      e_rdy  = (m_phase[i] != 0) && (occ >= FILT);
      e_done = (m_phase[i] == 2) && (occ < FILT);
      chk($sformatf("bre%0d", i),   int'(bre[i]),   int'(e_bre));
      chk($sformatf("wen%0d", i),   int'(wen[i]),   pend);
      chk($sformatf("waddr%0d", i), int'(waddr[i]), m_wr[i] % DEPTH);
      chk($sformatf("raddr%0d", i), int'(raddr[i]), (m_con[i] * stride_of(i)) % DEPTH);
      chk($sformatf("ready%0d", i), int'(wr[i]),    int'(e_rdy));
      chk($sformatf("busy%0d", i),  int'(busy[i]),  int'(m_phase[i] != 0));
      chk($sformatf("done%0d", i),  int'(rdone[i]), int'(e_done));
`ifdef IF_ZERO_PAD_EN
      chk($sformatf("pzero%0d", i), int'(pzero[i]), int'(pend == 1 && is_zero_slot(m_wr[i])));
      n_zero[i] += int'(wen[i] && pzero[i]);
`endif
      n_bre[i]  += int'(bre[i]);
      n_wen[i]  += int'(wen[i]);
      n_hon[i]  += int'(wcons[i] && wr[i]);
      n_done[i] += int'(rdone[i]);
      n_bad[i]  += int'(bre[i] && !bvalid);

      if (!rst) begin
        model_clear(i);
      end else begin
        hon = wcons[i] && e_rdy;
        if (m_phase[i] == 0 && start) m_phase[i] = 1;
        else if (m_phase[i] == 1 && m_iss[i] == TOTAL && pend == 0) m_phase[i] = 2;
        if (e_done) begin
          model_clear(i);
        end else begin
          m_con[i] += int'(hon);
          m_wr[i]  += pend;
          m_iss[i] += int'(can);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((m_phase[0] != 0 || m_phase[1] != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, n, r0, found;
    int first [2];
`ifdef IF_ZERO_PAD_EN
    int first_pz, last_pz;
`endif
    rst = 1'b0; start = 1'b0; bvalid = 1'b0;
    wcons[0] = 1'b0; wcons[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear(0);
    model_clear(1);
    clr_counts();
    tick();
    chk("reset_busy0", int'(busy[0]), 0);
    chk("reset_wen1", int'(wen[1]), 0);
    rst = 1'b1;
    tick();

    // Basic row with an eager consumer.
    clr_counts();
    bvalid = 1'b1; wcons[0] = 1'b1; wcons[1] = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    first[0] = -1; first[1] = -1;
`ifdef IF_ZERO_PAD_EN
    first_pz = -1; last_pz = -1;
`endif
    k = 1;
    while ((m_phase[0] != 0 || m_phase[1] != 0) && k < 400) begin
      for (int i = 0; i < 2; i++) if (wr[i] && first[i] < 0) first[i] = k;
`ifdef IF_ZERO_PAD_EN
      if (wen[0]) begin
        if (first_pz < 0) first_pz = int'(pzero[0]);
        last_pz = int'(pzero[0]);
      end
`endif
      tick();
      k++;
    end
    chk("basic_timeout", int'(k < 400), 1);
    // Counted from the edge that accepts start.
    chk("latency0", first[0] - 1, FILT + 1);
    chk("latency1", first[1] - 1, FILT + 1);
    chk("basic_reads0", n_bre[0], ROWL);
    chk("basic_reads1", n_bre[1], ROWL);
    chk("basic_writes0", n_wen[0], TOTAL);
    chk("basic_consumes0", n_hon[0], (TOTAL - FILT) / STR0 + 1);
    chk("basic_consumes1", n_hon[1], (TOTAL - FILT) / STR1 + 1);
    chk("basic_done0", n_done[0], 1);
    chk("basic_done1", n_done[1], 1);
`ifdef IF_ZERO_PAD_EN
    chk("zero_writes", n_zero[0], 2 * ZP);
    chk("zero_first", first_pz, 1);
    chk("zero_last", last_pz, 1);
`endif

    // Backpressure: no consumer until the pad is full.
    clr_counts();
    wcons[0] = 1'b0; wcons[1] = 1'b0; bvalid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    chk("bp_reads0", n_bre[0], DEPTH - ZP);
    chk("bp_reads1", n_bre[1], DEPTH - ZP);
    chk("bp_stall", int'(bre[0]), 0);
    wcons[0] = 1'b1; wcons[1] = 1'b1; tick();
    wcons[0] = 1'b0; wcons[1] = 1'b0;
    repeat (10) tick();
    chk("bp_more0", n_bre[0], DEPTH - ZP + STR0);
    chk("bp_more1", n_bre[1], DEPTH - ZP + STR1);
    wcons[0] = 1'b1; wcons[1] = 1'b1;
    run_until_idle(400, "bp_timeout");

    // Buffer starvation: valid alternates, consumer random.
    clr_counts();
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while ((m_phase[0] != 0 || m_phase[1] != 0) && k < 600) begin
      bvalid   = (k % 2) == 0;
      wcons[0] = 1'($urandom_range(0, 1));
      wcons[1] = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("starve_timeout", int'(k < 600), 1);
    chk("starve_bad0", n_bad[0], 0);
    chk("starve_reads0", n_bre[0], ROWL);
    chk("starve_reads1", n_bre[1], ROWL);

    // Write and honoured consume in one cycle, STRIDE=2, occupancy 5.
    clr_counts();
    bvalid = 1'b1; wcons[0] = 1'b0; wcons[1] = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    found = 0; n = 0;
    while (!found && n < 100) begin
      if (m_wr[1] - STR1 * m_con[1] == 5 && m_iss[1] - m_wr[1] == 1) found = 1;
      else begin tick(); n++; end
    end
    chk("simul_found", found, 1);
    chk("simul_wen", int'(wen[1]), 1);
    r0 = int'(raddr[1]);
    wcons[1] = 1'b1; tick(); wcons[1] = 1'b0;
    chk("simul_raddr", int'(raddr[1]), (r0 + STR1) % DEPTH);
    chk("simul_ready", int'(wr[1]), 1);
    wcons[0] = 1'b1; wcons[1] = 1'b1;
    run_until_idle(400, "simul_timeout");

    // Reset in the middle of a row.
    clr_counts();
    bvalid = 1'b1; wcons[0] = 1'b0; wcons[1] = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (n_bre[0] < 7 && n < 100) begin tick(); n++; end
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mid_busy0", int'(busy[0]), 0);
    chk("mid_wen0", int'(wen[0]), 0);
    chk("mid_bre0", int'(bre[0]), 0);
    chk("mid_waddr0", int'(waddr[0]), 0);
    chk("mid_busy1", int'(busy[1]), 0);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!wen[0] && n < 50) begin tick(); n++; end
    chk("rerow_wen", int'(wen[0]), 1);
    chk("rerow_waddr", int'(waddr[0]), 0);
    wcons[0] = 1'b1; wcons[1] = 1'b1;
    run_until_idle(400, "rerow_timeout");

    // Random traffic, including start while busy and occasional resets.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 200; j++) begin
        start    = $urandom_range(0, 15) == 0;
        bvalid   = $urandom_range(0, 3) != 0;
        wcons[0] = 1'($urandom_range(0, 1));
        wcons[1] = 1'($urandom_range(0, 1));
        rst      = $urandom_range(0, 255) != 0;
        tick();
      end
    end
    start = 1'b0; rst = 1'b1; bvalid = 1'b1;
    wcons[0] = 1'b1; wcons[1] = 1'b1;
    run_until_idle(400, "rand_timeout");

    $display("%0d/%0d checks passed", cnt_pass, cnt_total);
    $finish;
  end

endmodule
